// File: rtl/key_debouncer_pkg.sv
// Board-level constants shared by the key conditioning logic.
package key_debouncer_pkg;

  localparam int CLK_FREQ_HZ = 100_000_000;
  localparam int BOARD_N_KEYS = 3;
  localparam int DEBOUNCE_MS = 10;

  function automatic int debounce_cycles(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

  localparam int BOARD_STABLE_CYCLES = debounce_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);

endpackage

// File: rtl/key_debouncer_if.sv
// Raw key bus in, debounced level and press/release pulses out.
import key_debouncer_pkg::*;

interface key_debouncer_if #(
  parameter int N_KEYS = BOARD_N_KEYS
);
  logic [N_KEYS-1:0] key_i;
  logic [N_KEYS-1:0] key_state_o;
  logic [N_KEYS-1:0] key_press_o;
  logic [N_KEYS-1:0] key_release_o;

  modport master (output key_i, input key_state_o, input key_press_o, input key_release_o);
  modport slave  (input key_i, output key_state_o, output key_press_o, output key_release_o);
endinterface

// File: rtl/key_debouncer_channel.sv
// One key: 2-FF synchroniser, hold-time counter and one-cycle press/release pulses.
import key_debouncer_pkg::*;

module key_debouncer_channel #(
  parameter int STABLE_CYCLES = 8,
  parameter bit IDLE_LVL      = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic state_o,
  output logic press_o,
  output logic release_o
);
  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             norm;

  // Pressed is 1 after this point regardless of board polarity.
  assign norm = sync2_q ^ IDLE_LVL;

  always_comb begin
    stable_d  = stable_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (norm != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d  = norm;
        press_d   = norm;
        release_d = ~norm;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q   <= IDLE_LVL;
      sync2_q   <= IDLE_LVL;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= key_i;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign state_o   = stable_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_debouncer.sv
// Push-button conditioner: one independent debounce channel per key, packed onto the key bus.
import key_debouncer_pkg::*;

module key_debouncer #(
  parameter int N_KEYS        = BOARD_N_KEYS,
  parameter int STABLE_CYCLES = BOARD_STABLE_CYCLES,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic            clk100_i,
  input  logic            rst_i,
  key_debouncer_if.slave  kif
);
  // Idle raw level is the opposite of the pressed level.
  localparam bit IDLE_LVL = (ACTIVE_LOW != 0);

  logic [N_KEYS-1:0] state_w, press_w, release_w;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debouncer_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .IDLE_LVL      (IDLE_LVL)
    ) u_ch (
      .clk_i     (clk100_i),
      .rst_i     (rst_i),
      .key_i     (kif.key_i[g]),
      .state_o   (state_w[g]),
      .press_o   (press_w[g]),
      .release_o (release_w[g])
    );
  end

  assign kif.key_state_o   = state_w;
  assign kif.key_press_o   = press_w;
  assign kif.key_release_o = release_w;

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench for key_debouncer with STABLE_CYCLES = 8 on a 10 ns clock.
module tb_key_debouncer;

  localparam int LAT = 10;  // drive cycle -> pulse observed: 1 (edge 0) + STABLE_CYCLES + 1

  typedef struct {
    int       cyc;
    logic [2:0] press;
    logic [2:0] rel;
    logic [2:0] state;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  ev_t  sb_q[$];

  key_debouncer_if #(.N_KEYS(3)) kif ();

  key_debouncer #(
    .N_KEYS        (3),
    .STABLE_CYCLES (8),
    .ACTIVE_LOW    (1)
  ) dut (
    .clk100_i (clk),
    .rst_i    (rst),
    .kif      (kif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic [2:0] v);
    @(posedge clk);
    #2;
    kif.key_i = v;
  endtask

  task automatic expect_ev(input logic [2:0] p, input logic [2:0] r, input logic [2:0] s);
    ev_t e;
    e.cyc   = cyc + LAT;
    e.press = p;
    e.rel   = r;
    e.state = s;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Monitor: pops an expected event whenever the DUT shows a pulse.
  initial begin : monitor
    logic [2:0] p, r, prev_p, prev_r, sb_state;
    ev_t e;
    prev_p = '0;
    prev_r = '0;
    sb_state = '0;
    forever begin
      @(negedge clk);
      p = kif.key_press_o;
      r = kif.key_release_o;
      if (rst) begin
        chk("reset_outputs", {kif.key_state_o, p, r}, 0);
        sb_state = '0;
        prev_p = '0;
        prev_r = '0;
      end else begin
        if ((p | r) != 3'b000) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pulse: press=%b release=%b expected none (cycle %0d)", p, r, cyc);
          end else begin
            e = sb_q.pop_front();
            chk("pulse_cycle", cyc, e.cyc);
            chk("press_mask", p, e.press);
            chk("release_mask", r, e.rel);
            sb_state = e.state;
          end
        end else if (sb_q.size() != 0 && cyc > sb_q[0].cyc) begin
          e = sb_q.pop_front();
          n_tests++;
          n_fail++;
          $display("FAIL missed_pulse: no pulse, expected press=%b release=%b at cycle %0d", e.press, e.rel, e.cyc);
          sb_state = e.state;
        end
        chk("key_state", kif.key_state_o, sb_state);
        chk("no_double_pulse", (p & prev_p) | (r & prev_r), 0);
        prev_p = p;
        prev_r = r;
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1;
    kif.key_i = 3'b111;

    // Reset with keys idle, then quiet hold.
    idle(5);
    #2 rst = 1'b0;
    idle(30);

    // Clean press of key 0.
    drive(3'b110);
    expect_ev(3'b001, 3'b000, 3'b001);
    idle(20);

    // Clean release of key 0.
    drive(3'b111);
    expect_ev(3'b000, 3'b001, 3'b000);
    idle(20);

    // Bouncing press: one pulse, timed from the last transition.
    drive(3'b110); idle(2);
    drive(3'b111); idle(2);
    drive(3'b110); idle(2);
    drive(3'b111); idle(2);
    drive(3'b110);
    expect_ev(3'b001, 3'b000, 3'b001);
    idle(20);
    drive(3'b111);
    expect_ev(3'b000, 3'b001, 3'b000);
    idle(20);

    // Short glitch on key 1 is rejected.
    drive(3'b101);
    idle(4);
    drive(3'b111);
    idle(20);

    // Simultaneous press and release of keys 0 and 2.
    drive(3'b010);
    expect_ev(3'b101, 3'b000, 3'b101);
    idle(20);
    drive(3'b111);
    expect_ev(3'b000, 3'b101, 3'b000);
    idle(20);

    // Reset mid-count discards the press; the held key is then debounced afresh.
    drive(3'b110);
    idle(4);
    #2 rst = 1'b1;
    #1 chk("async_reset_state", kif.key_state_o, 0);
    idle(3);
    #2 rst = 1'b0;
    expect_ev(3'b001, 3'b000, 3'b001);
    idle(20);
    drive(3'b111);
    expect_ev(3'b000, 3'b001, 3'b000);
    idle(20);

    chk("pending_events", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
